// File: rtl/video_pkg.sv
// Shared video definitions: frame defaults, pixel colours and the pattern writer FSM encoding.
package video_pkg;

    localparam int DEF_HDISP = 800;
    localparam int DEF_VDISP = 480;

    localparam logic [31:0] PIX_WHITE = 32'h00FF_FFFF;
    localparam logic [31:0] PIX_BLACK = 32'h0000_0000;

    typedef enum logic [1:0] {
        PW_IDLE  = 2'd0,
        PW_WRITE = 2'd1,
        PW_GAP   = 2'd2,
        PW_DONE  = 2'd3
    } pw_state_t;

    // True when a coordinate lies on a grid line; grid must be a power of two.
    function automatic logic onGrid(input logic [31:0] coord, input int grid);
        return (coord & 32'(grid - 1)) == 32'd0;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 classic bus bundle with master and slave views.
interface wshb_if #(
    parameter int DATA_BYTES = 1,
    parameter int ADR_WIDTH  = 32
) ();

    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic [ADR_WIDTH-1:0]    adr;
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [DATA_BYTES-1:0]   sel;
    logic                    ack;
    logic                    err;
    logic                    rty;
    logic [2:0]              cti;
    logic [1:0]              bte;

    modport master (
        output cyc, stb, we, sel, adr, dat_ms, cti, bte,
        input  ack, err, rty, dat_sm
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_ms, cti, bte,
        output ack, err, rty, dat_sm
    );

endinterface

// File: rtl/xy_scan.sv
// Raster x/y counter: clear to (0,0), advance one pixel in row-major order, flag the last pixel.
module xy_scan
    import video_pkg::*;
#(
    parameter int HDISP = DEF_HDISP,
    parameter int VDISP = DEF_VDISP,
    localparam int XW   = (HDISP > 1) ? $clog2(HDISP) : 1,
    localparam int YW   = (VDISP > 1) ? $clog2(VDISP) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    localparam logic [XW-1:0] XMAX = XW'(HDISP - 1);
    localparam logic [YW-1:0] YMAX = YW'(VDISP - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (x_q == XMAX) begin
                x_d = '0;
                y_d = (y_q == YMAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == XMAX) && (y_q == YMAX);

endmodule

// File: rtl/wshb_pattern_writer.sv
// Wishbone classic master that writes one grid-pattern frame into SDRAM, retrying on err/rty.
module wshb_pattern_writer
    import video_pkg::*;
#(
    parameter int          HDISP    = DEF_HDISP,
    parameter int          VDISP    = DEF_VDISP,
    parameter int          GRID     = 16,
    parameter logic [31:0] BASE_ADR = 32'h0
) (
    input  logic   sys_clk,
    input  logic   sys_rst,
    input  logic   start,
    output logic   busy,
    output logic   done,
    wshb_if.master wshb_ifm
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;

    pw_state_t     state_q, state_d;
    logic [31:0]   adr_q, adr_d;
    logic          scanClear;
    logic          scanAdvance;
    logic          lastPix;
    logic [XW-1:0] xPos;
    logic [YW-1:0] yPos;
    logic [31:0]   pixel;

    xy_scan #(
        .HDISP(HDISP),
        .VDISP(VDISP)
    ) u_scan (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .clear_i  (scanClear),
        .advance_i(scanAdvance),
        .x_o      (xPos),
        .y_o      (yPos),
        .last_o   (lastPix)
    );

    // ack wins over err/rty; a failed transfer parks in GAP and repeats the same pixel.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        scanClear   = 1'b0;
        scanAdvance = 1'b0;
        case (state_q)
            PW_IDLE, PW_DONE: begin
                if (start) begin
                    state_d   = PW_WRITE;
                    scanClear = 1'b1;
                    adr_d     = BASE_ADR;
                end
            end
            PW_WRITE: begin
                if (wshb_ifm.ack) begin
                    adr_d = adr_q + 32'd4;
                    if (lastPix) begin
                        state_d = PW_DONE;
                    end else begin
                        scanAdvance = 1'b1;
                    end
                end else if (wshb_ifm.err || wshb_ifm.rty) begin
                    state_d = PW_GAP;
                end
            end
            PW_GAP: begin
                state_d = PW_WRITE;
            end
            default: begin
                state_d = PW_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= PW_IDLE;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
        end
    end

    assign pixel = (onGrid(32'(xPos), GRID) || onGrid(32'(yPos), GRID)) ? PIX_WHITE : PIX_BLACK;

    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.sel    = '0;
        wshb_ifm.adr    = '0;
        wshb_ifm.dat_ms = '0;
        wshb_ifm.cti    = 3'b000;
        wshb_ifm.bte    = 2'b00;
        if (state_q == PW_WRITE) begin
            wshb_ifm.cyc    = 1'b1;
            wshb_ifm.stb    = 1'b1;
            wshb_ifm.we     = 1'b1;
            wshb_ifm.sel    = '1;
            wshb_ifm.adr    = adr_q;
            wshb_ifm.dat_ms = pixel;
        end
    end

    assign busy = (state_q == PW_WRITE) || (state_q == PW_GAP);
    assign done = (state_q == PW_DONE);

endmodule

// File: tb/tb_wshb_pattern_writer.sv
// Scoreboard bench for wshb_pattern_writer against a randomised Wishbone slave.
module tb_wshb_pattern_writer;

    localparam int          H    = 4;
    localparam int          V    = 3;
    localparam int          G    = 2;
    localparam logic [31:0] BASE = 32'h0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    wshb_if #(.DATA_BYTES(4)) bus ();

    wshb_pattern_writer #(
        .HDISP   (H),
        .VDISP   (V),
        .GRID    (G),
        .BASE_ADR(BASE)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .wshb_ifm(bus.master)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int          waitMin = 0;
    int          waitMax = 0;
    int          errPct = 0;
    bit          strayAck = 0;
    bit          forceErrArmed = 0;
    logic [31:0] forceErrAdr = 32'h0;

    int ackCount = 0;
    int writeCycles = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference frame: row-major pixels, white on any grid row or column.
    task automatic pushFrame();
        exp_t e;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                e.adr = BASE + 32'(4 * (y * H + x));
                e.dat = ((x % G) == 0 || (y % G) == 0) ? 32'h00FF_FFFF : 32'h0;
                sb.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus();
        pushFrame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput(name, done, 1'b1);
        checkOutput({name, "_busy"}, busy, 1'b0);
        checkOutput({name, "_cyc"}, bus.cyc, 1'b0);
        checkOutput({name, "_sb_left"}, sb.size(), 0);
        sb.delete();
    endtask

    // Slave: optional wait states, injected err/rty, and stray responses while the bus is idle.
    bit active = 0;
    int waitCnt = 0;
    int waitTarget = 0;
    always @(negedge clk) begin
        bus.ack = 1'b0;
        bus.err = 1'b0;
        bus.rty = 1'b0;
        if (bus.cyc && bus.stb) begin
            if (!active) begin
                active     = 1;
                waitCnt    = 0;
                waitTarget = $urandom_range(waitMax, waitMin);
            end
            if (waitCnt < waitTarget) begin
                waitCnt++;
            end else begin
                active = 0;
                if (forceErrArmed && bus.adr == forceErrAdr) begin
                    bus.err       = 1'b1;
                    forceErrArmed = 0;
                end else if (errPct > 0 && $urandom_range(99, 0) < errPct) begin
                    if ($urandom_range(1, 0) == 1) bus.err = 1'b1;
                    else                           bus.rty = 1'b1;
                end else begin
                    bus.ack = 1'b1;
                    if (errPct > 0 && $urandom_range(3, 0) == 0) bus.err = 1'b1;
                end
            end
        end else begin
            active = 0;
            if (strayAck) begin
                bus.ack = 1'($urandom_range(1, 0));
                bus.rty = 1'($urandom_range(1, 0));
            end
        end
    end

    // Monitor: pops the scoreboard on every acked write and checks hold/gap/retry behaviour.
    bit          stallPrev = 0;
    bit          retryPrev = 0;
    bit          gapPrev = 0;
    logic [31:0] holdAdr, holdDat, retryAdr, retryDat;
    always @(negedge clk) begin
        #1;
        if (rst) begin
            stallPrev = 0;
            retryPrev = 0;
            gapPrev   = 0;
        end else begin
            if (bus.cyc) writeCycles++;
            if (gapPrev) begin
                checkOutput("retry_cyc", bus.cyc, 1'b1);
                checkOutput("retry_adr", bus.adr, retryAdr);
                checkOutput("retry_dat", bus.dat_ms, retryDat);
                gapPrev = 0;
            end
            if (retryPrev) begin
                checkOutput("gap_cyc", bus.cyc, 1'b0);
                checkOutput("gap_busy", busy, 1'b1);
                retryPrev = 0;
                gapPrev   = 1;
            end
            if (stallPrev) begin
                checkOutput("hold_adr", bus.adr, holdAdr);
                checkOutput("hold_dat", bus.dat_ms, holdDat);
                stallPrev = 0;
            end
            if (bus.cyc) begin
                checkOutput("ctrl", 32'({bus.stb, bus.we, bus.sel, bus.cti, bus.bte}),
                            32'({1'b1, 1'b1, 4'hF, 3'b000, 2'b00}));
                if (bus.ack) begin
                    checkOutput("sb_nonempty", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        checkOutput("wr_adr", bus.adr, e.adr);
                        checkOutput("wr_dat", bus.dat_ms, e.dat);
                    end
                    ackCount++;
                end else if (bus.err || bus.rty) begin
                    retryPrev = 1;
                    retryAdr  = bus.adr;
                    retryDat  = bus.dat_ms;
                end else begin
                    stallPrev = 1;
                    holdAdr   = bus.adr;
                    holdDat   = bus.dat_ms;
                end
            end else begin
                checkOutput("idle_ctrl", 32'({bus.stb, bus.we, bus.sel}), 0);
                checkOutput("idle_adr", bus.adr, 0);
                checkOutput("idle_dat", bus.dat_ms, 0);
            end
        end
    end

    initial begin
        int n;
        int base;
        rst        = 1'b1;
        start      = 1'b0;
        bus.dat_sm = '0;
        bus.ack    = 1'b0;
        bus.err    = 1'b0;
        bus.rty    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset and idle");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            checkOutput("rst_cyc", bus.cyc, 1'b0);
            checkOutput("rst_stb", bus.stb, 1'b0);
            checkOutput("rst_busy", busy, 1'b0);
            checkOutput("rst_done", done, 1'b0);
        end

        $display("[TB] zero-wait frame");
        writeCycles = 0;
        applyStimulus();
        waitDone(200, "zw_done");
        checkOutput("zw_cycles", writeCycles, H * V);

        $display("[TB] two wait states");
        waitMin = 2;
        waitMax = 2;
        writeCycles = 0;
        applyStimulus();
        waitDone(400, "ws_done");
        checkOutput("ws_cycles", writeCycles, 3 * H * V);

        $display("[TB] err at adr 20");
        waitMin = 0;
        waitMax = 0;
        forceErrAdr   = 32'd20;
        forceErrArmed = 1;
        writeCycles = 0;
        applyStimulus();
        waitDone(200, "err_done");
        checkOutput("err_cycles", writeCycles, H * V + 1);

        $display("[TB] reset mid-frame");
        base = ackCount;
        applyStimulus();
        n = 0;
        while (ackCount < base + 4 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("rst_reach5", 32'(ackCount >= base + 4), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("midrst_cyc", bus.cyc, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        rst = 1'b0;
        sb.delete();
        applyStimulus();
        waitDone(200, "rst_restart_done");

        $display("[TB] start during WRITE and in DONE");
        waitMin = 0;
        waitMax = 2;
        base = ackCount;
        applyStimulus();
        n = 0;
        while (ackCount < base + 6 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(400, "ign_done");
        repeat (3) @(negedge clk);
        #2;
        checkOutput("done_held", done, 1'b1);
        applyStimulus();
        #2;
        checkOutput("redo_done_fall", done, 1'b0);
        checkOutput("redo_busy", busy, 1'b1);
        waitDone(400, "redo_done");

        $display("[TB] randomized frames");
        waitMin  = 0;
        waitMax  = 3;
        errPct   = 20;
        strayAck = 1;
        for (int f = 0; f < 4; f++) begin
            applyStimulus();
            waitDone(2000, "rand_done");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wshb_pattern_writer.md
# wshb_pattern_writer

Wishbone B4 classic master that fills one frame buffer in SDRAM with a grid test pattern, one 32-bit pixel per transfer. It drives the SDRAM-side Wishbone bus, `wshb_if_sdram`, which is otherwise tied off in `Top`, and runs in the `sys_clk` (100 MHz) domain. It gives the video chain a known frame to read back and display before a real pixel source exists.

## Interface
Parameters:
- `HDISP`, 800: frame width in pixels.
- `VDISP`, 480: frame height in pixels.
- `GRID`, 16: grid pitch in pixels; must be a power of 2 and ≥ 2.
- `BASE_ADR`, 0: byte address of pixel (0,0); must be 4-byte aligned.

Ports:
- `sys_clk`  in  1  system clock, 100 MHz; single clock domain.
- `sys_rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to (re)write the frame; honoured only in IDLE or DONE.
- `busy`  out  1  high while in WRITE or GAP.
- `done`  out  1  high in DONE; held until the next accepted `start` or reset.
- `wshb_ifm`  master modport  `wshb_if` with `DATA_BYTES=4`  Wishbone master port.

## Operation
- FSM states: IDLE, WRITE, GAP, DONE.
- Transitions:
  - IDLE or DONE, with `start` → WRITE; x, y and the address pointer are cleared to pixel (0,0).
  - WRITE, on `ack` at the last pixel (x=HDISP-1, y=VDISP-1) → DONE.
  - WRITE, on `ack` at any other pixel → stay in WRITE; advance x, wrapping to 0 and incrementing y at HDISP-1.
  - WRITE, on `err` or `rty` (without `ack`) → GAP; x, y and address are unchanged.
  - GAP → WRITE unconditionally after one cycle; the same pixel is retried.
- Bus outputs in WRITE:
  - `cyc`=`stb`=1, `we`=1, `sel`=4'hF, `cti`=3'b000, `bte`=2'b00.
  - `adr` = BASE_ADR + 4·(y·HDISP + x). Kept in an incrementing pointer (+4 per `ack`); no multiplier.
  - `dat_ms` = 32'h00FF_FFFF when x mod GRID = 0 or y mod GRID = 0, else 32'h0000_0000. Use the low bits of x and y only.
- Bus outputs in IDLE, GAP and DONE: `cyc`=`stb`=`we`=0, `sel`=0, `adr`=0, `dat_ms`=0.
- `ack`, `err` and `rty` are ignored outside WRITE. Simultaneous `ack` and `err` counts as `ack`.
- `start` in WRITE or GAP is ignored; no queuing.
- Widths: x uses $clog2(HDISP) bits, y uses $clog2(VDISP) bits, address is 32 bits. No wrap occurs inside a frame.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, all bus outputs 0, x=y=0.
- Reset asserted mid-frame: `cyc`/`stb` fall at the next edge; the partial frame is abandoned.
- Latency:
  - `start` sampled at edge N → `cyc`/`stb` high after edge N, for the first transfer.
  - Same-cycle `ack` (combinational slave) sustains one pixel per cycle, so a frame takes HDISP·VDISP cycles.
  - Last `ack` at edge M → `done`=1 and `cyc`=0 after edge M.
- Wait states: `stb`, `adr` and `dat_ms` are held stable until `ack`, `err` or `rty`.
- Retry cost: each `err` or `rty` costs exactly one idle cycle (GAP) with `cyc`=0.

## Structure
- Package `video_pkg`:
  - FSM enum `pw_state_t`.
  - Colour constants `PIX_WHITE` and `PIX_BLACK`.
  - Shared defaults for HDISP and VDISP.
- One sub-module, `xy_scan`: x/y raster counter with clear, advance and last-pixel flag. It is reusable by the future frame reader.
- Everything else lives in `wshb_pattern_writer`.

## Test plan
Unless stated otherwise: HDISP=4, VDISP=3, GRID=2, BASE_ADR=0.
- Reset then idle 10 cycles → `cyc`=`stb`=0, `busy`=0, `done`=0 throughout.
- `start` pulse with slave `ack`=`stb` (zero wait) → 12 writes at adr 0,4,…,44 on consecutive cycles; data per row is y0 all white, y1 W,K,W,K, y2 all white; `done`=1 after the 12th ack.
- Slave inserts 2 wait states per transfer → `adr`/`dat_ms` stable while `ack`=0; 12 writes total; `done` after 36 cycles of WRITE.
- `err` asserted on the transfer at adr 20 → one cycle with `cyc`=0, then adr 20 repeated with the same data; frame completes with 12 acked writes.
- `sys_rst` asserted at the 5th transfer → `cyc` low next cycle; after release plus `start`, writing restarts at adr 0.
- `start` pulsed during WRITE → ignored; `start` in DONE → `done` falls and the frame is rewritten from adr 0.
